// File: rtl/spu_issue_buffer.sv
// spu_issue_buffer: pair-wide instruction queue with in-order even/odd pipe issue.
// Define DUAL_ISSUE_EN to let both instructions of a pair issue in the same cycle.
module spu_issue_buffer #(
    parameter int bitsize = 11,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_valid,
    input  logic [31:0]        instruction1,
    input  logic [31:0]        instruction2,
    input  logic [bitsize-1:0] fetch_pc,
    output logic               fetch_ready,
    input  logic               flush,
    input  logic               issue_stall,
    output logic               even_valid,
    output logic [31:0]        even_inst,
    output logic [bitsize-1:0] even_pc,
    output logic               odd_valid,
    output logic [31:0]        odd_inst,
    output logic [bitsize-1:0] odd_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [31:0]        mem_i1 [DEPTH];
    logic [31:0]        mem_i2 [DEPTH];
    logic [bitsize-1:0] mem_pc [DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      count;
    logic               half;
    logic [31:0]        h1, h2, sel;
    logic [bitsize-1:0] hpc, hpc2, sel_pc;
    logic               push, pop, issue, dual, sel_odd, go_even, go_odd;
    assign fetch_ready = count != CW'(DEPTH);
    assign push    = fetch_valid && fetch_ready && !flush;
    assign issue   = !issue_stall && !flush && count != '0;
    assign h1      = mem_i1[rd_ptr];
    assign h2      = mem_i2[rd_ptr];
    assign hpc     = mem_pc[rd_ptr];
    assign hpc2    = hpc + bitsize'(1);
`ifdef DUAL_ISSUE_EN
    assign dual = !half && h1[31:28] != 4'b0011 && h2[31:28] == 4'b0011
                  && h2[13:7] != h1[6:0] && h2[20:14] != h1[6:0];
`else
    assign dual = 1'b0;
`endif
    // Single issue routes the pending half of the head pair to its class pipe.
    assign sel     = half ? h2 : h1;
    assign sel_pc  = half ? hpc2 : hpc;
    assign sel_odd = sel[31:28] == 4'b0011;
    assign go_even = issue && (dual || !sel_odd);
    assign go_odd  = issue && (dual || sel_odd);
    assign pop     = issue && (half || dual);
    always_ff @(posedge clk) begin
        if (push) begin
            mem_i1[wr_ptr] <= instruction1;
            mem_i2[wr_ptr] <= instruction2;
            mem_pc[wr_ptr] <= fetch_pc;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            half       <= 1'b0;
            even_valid <= 1'b0;
            odd_valid  <= 1'b0;
            even_inst  <= '0;
            even_pc    <= '0;
            odd_inst   <= '0;
            odd_pc     <= '0;
        end else if (flush) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            half       <= 1'b0;
            even_valid <= 1'b0;
            odd_valid  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (!issue_stall) begin
                even_valid <= go_even;
                odd_valid  <= go_odd;
                if (issue)
                    half <= !half && !dual;
                if (go_even) begin
                    even_inst <= sel;
                    even_pc   <= sel_pc;
                end
                if (go_odd) begin
                    odd_inst <= dual ? h2 : sel;
                    odd_pc   <= dual ? hpc2 : sel_pc;
                end
            end
        end
    end
endmodule
